// File: rtl/alu_pkg.sv
// Shared definitions for the sequencing ALU: operation encodings, FSM states,
// and the classifier that routes an operation to the iterative engine.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SRA   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_REM   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Multiply/divide family; the reserved 101x codes complete in one cycle.
    function automatic logic is_iterative(input logic [3:0] sel);
        return sel[3] && (sel[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Bit-serial engine: shift-add multiplier and restoring divider, one bit per
// cycle for XLEN cycles; signed divide handled by abs-in / negate-out.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic [2:0]      op_q;
    logic            negq_q, negr_q;

    logic            signed_div, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b, base;
    logic [XLEN:0]   sum, shifted;
    logic [XLEN+1:0] diff;
    logic            neg;

    assign signed_div = (op_i == OP_DIV) || (op_i == OP_REM);
    assign sign_a     = signed_div && a_i[XLEN-1];
    assign sign_b     = signed_div && b_i[XLEN-1];
    assign abs_a      = sign_a ? -a_i : a_i;
    assign abs_b      = sign_b ? -b_i : b_i;

    // hi holds partial product / partial remainder, lo holds multiplier / quotient.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opb_q};
        if (op_q[2]) begin
            if (!diff[XLEN+1]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = shifted[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
    end

    // The final step is taken combinationally so the result lands on the done edge.
    assign base     = op_q[0] ? hi_d : lo_d;
    assign neg      = op_q[2] && op_q[1] && (op_q[0] ? negr_q : negq_q);
    assign result_o = neg ? -base : base;
    assign done_o   = busy_q && (cnt_q == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            op_q   <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            hi_q   <= '0;
            lo_q   <= op_i[2] ? abs_a : a_i;
            opb_q  <= op_i[2] ? abs_b : b_i;
            op_q   <= op_i[2:0];
            // A zero divisor must leave the all-ones quotient un-negated.
            negq_q <= (sign_a ^ sign_b) && (b_i != '0);
            negr_q <= sign_a;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Valid/ready ALU: single-cycle ops computed here, multiply/divide handed to
// muldiv_iter; a three-state FSM owns handshaking and the result register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [3:0]      alusel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] alu_out, eng_result;
    logic [SHW-1:0]  shamt;
    logic            accept, iter_sel, eng_done;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = (state_q != ST_BUSY) && (!out_valid || out_ready) && !flush && !rst;
    assign accept    = in_valid && in_ready;
    assign iter_sel  = is_iterative(alusel);
    assign shamt     = operand2[SHW-1:0];
    assign result    = result_q;

    always_comb begin
        alu_out = '0;
        case (alusel)
            OP_ADD:  alu_out = operand1 + operand2;
            OP_SLL:  alu_out = operand1 << shamt;
            OP_SUB:  alu_out = operand1 - operand2;
            OP_SRA:  alu_out = $signed(operand1) >>> shamt;
            OP_XOR:  alu_out = operand1 ^ operand2;
            OP_SRL:  alu_out = operand1 >> shamt;
            OP_OR:   alu_out = operand1 | operand2;
            OP_AND:  alu_out = operand1 & operand2;
            default: alu_out = '0;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .start_i  (accept && iter_sel),
        .op_i     (alusel),
        .a_i      (operand1),
        .b_i      (operand2),
        .done_o   (eng_done),
        .result_o (eng_result)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = iter_sel ? ST_BUSY : ST_HOLD;
                ST_BUSY: if (eng_done) begin
                    state_d  = ST_HOLD;
                    result_d = eng_result;
                end
                ST_HOLD: if (out_ready) state_d = accept ? (iter_sel ? ST_BUSY : ST_HOLD) : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            if (accept && !iter_sel) begin
                result_d = alu_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Drives XLEN=16/32/64 instances from one shared request bus and checks every
// result and latency against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [3:0]  alusel;
    logic [63:0] op_a, op_b;
    logic [2:0]  rdy, ov;
    logic [15:0] r16;
    logic [31:0] r32;
    logic [63:0] r64;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last32;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(16)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .operand1(op_a[15:0]), .operand2(op_b[15:0]), .alusel(alusel),
        .out_valid(ov[0]), .out_ready(out_ready), .result(r16)
    );
    alu_seq #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .operand1(op_a[31:0]), .operand2(op_b[31:0]), .alusel(alusel),
        .out_valid(ov[1]), .out_ready(out_ready), .result(r32)
    );
    alu_seq #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .operand1(op_a), .operand2(op_b), .alusel(alusel),
        .out_valid(ov[2]), .out_ready(out_ready), .result(r64)
    );

    function automatic int width_of(input int k);
        return 16 << k;
    endfunction

    function automatic logic [63:0] res_of(input int k);
        case (k)
            0:       return {48'b0, r16};
            1:       return {32'b0, r32};
            default: return r64;
        endcase
    endfunction

    function automatic bit is_iter(input logic [3:0] sel);
        return sel[3] && !(sel[2:1] == 2'b01);
    endfunction

    // Reference semantics computed with wide plain arithmetic, then truncated to w.
    function automatic logic [63:0] model(input int w, input logic [3:0] sel,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]  mask, a, b, res;
        logic [127:0] p;
        longint       sa, sb;
        int           sh;
        bit           ovf;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        sh   = int'(b & 64'(w - 1));
        sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb   = b[w-1] ? longint'(b | ~mask) : longint'(b);
        ovf  = (a == (64'd1 << (w - 1))) && (b == mask);
        p    = {64'b0, a} * {64'b0, b};
        case (sel)
            4'd0:    res = a + b;
            4'd1:    res = a << sh;
            4'd2:    res = a - b;
            4'd3:    res = 64'(sa >>> sh);
            4'd4:    res = a ^ b;
            4'd5:    res = a >> sh;
            4'd6:    res = a | b;
            4'd7:    res = a & b;
            4'd8:    res = p[63:0];
            4'd9:    res = 64'(p >> w);
            4'd12:   res = (b == 0) ? '1 : a / b;
            4'd13:   res = (b == 0) ? a : a % b;
            4'd14:   res = (b == 0) ? '1 : (ovf ? a : 64'(sa / sb));
            4'd15:   res = (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
            default: res = '0;
        endcase
        return res & mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy != 3'b111 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (rdy != 3'b111) begin
            errors++;
            $display("FAIL wait_ready: in_ready=%b required 111", rdy);
        end
    endtask

    // One request issued to all three widths; latency and value checked per width.
    task automatic run_op(input logic [3:0] sel, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp_v[3];
        logic [63:0] got[3];
        int          lat[3];
        logic [2:0]  seen = '0;
        bit          rdy_bad = 0;
        int          n = 1;
        wait_ready();
        alusel = sel; op_a = a; op_b = b; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_v[k] = model(width_of(k), sel, a, b);
            lat[k] = 0;
            got[k] = '0;
        end
        step();
        in_valid = 1'b0;
        while (seen != 3'b111 && n <= 80) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k]) begin
                    if (ov[k]) begin
                        seen[k] = 1'b1;
                        lat[k]  = n;
                        got[k]  = res_of(k);
                    end else if (rdy[k]) begin
                        rdy_bad = 1;
                    end
                end
            end
            if (seen != 3'b111) begin
                step();
                n++;
            end
        end
        last32 = got[1][31:0];
        $display("op sel=%h a=%h b=%h r16=%h r32=%h r64=%h lat=%0d/%0d/%0d",
                 sel, a, b, got[0], got[1], got[2], lat[0], lat[1], lat[2]);
        for (int k = 0; k < 3; k++) begin
            int exp_lat = is_iter(sel) ? width_of(k) + 1 : 1;
            checks++;
            if (lat[k] != exp_lat) begin
                errors++;
                $display("FAIL latency w=%0d sel=%h: got %0d required %0d", width_of(k), sel, lat[k], exp_lat);
            end
            checks++;
            if (got[k] !== exp_v[k]) begin
                errors++;
                $display("FAIL result w=%0d sel=%h a=%h b=%h: got %h required %h",
                         width_of(k), sel, a, b, got[k], exp_v[k]);
            end
        end
        if (is_iter(sel)) begin
            checks++;
            if (rdy_bad) begin
                errors++;
                $display("FAIL busy_ready sel=%h: in_ready seen 1 while busy, required 0", sel);
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alusel = '0; op_a = '0; op_b = '0;
        step(); step(); step();
        checks++;
        if (ov !== 3'b000 || rdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b in_ready=%b required 000/000", ov, rdy);
        end
        checks++;
        if (r16 !== '0 || r32 !== '0 || r64 !== '0) begin
            errors++;
            $display("FAIL reset_result: %h %h %h required 0", r16, r32, r64);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 111", rdy);
        end
    endtask

    task automatic test_directed();
        run_op(4'b0000, 64'h7FFF_FFFF, 64'h1);
        checks++;
        if (last32 !== 32'h8000_0000) begin errors++; $display("FAIL add_wrap: got %h required 80000000", last32); end
        run_op(4'b0011, 64'h8000_0000, 64'h24);
        checks++;
        if (last32 !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h required f8000000", last32); end
        run_op(4'b1000, '1, '1);
        checks++;
        if (last32 !== 32'h0000_0001) begin errors++; $display("FAIL mul_ones: got %h required 00000001", last32); end
        run_op(4'b1001, '1, '1);
        checks++;
        if (last32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_ones: got %h required fffffffe", last32); end
        run_op(4'b1110, 64'h8000_0000, 64'hFFFF_FFFF);
        checks++;
        if (last32 !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got %h required 80000000", last32); end
        run_op(4'b1111, 64'h8000_0000, 64'hFFFF_FFFF);
        checks++;
        if (last32 !== 32'h0) begin errors++; $display("FAIL rem_ovf: got %h required 0", last32); end
        run_op(4'b1100, 64'd7, 64'd0);
        checks++;
        if (last32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero: got %h required ffffffff", last32); end
        run_op(4'b1101, 64'd7, 64'd0);
        checks++;
        if (last32 !== 32'd7) begin errors++; $display("FAIL remu_zero: got %h required 7", last32); end
        run_op(4'b1110, -64'sd7, 64'd2);
        checks++;
        if (last32 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg: got %h required fffffffd", last32); end
        run_op(4'b1111, -64'sd7, 64'd2);
        checks++;
        if (last32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h required ffffffff", last32); end
        run_op(4'b1010, 64'h1234, 64'h5678);
        run_op(4'b1011, '1, '1);
        run_op(4'b1110, 64'h8000, '1);
        run_op(4'b1111, 64'h8000_0000_0000_0000, '1);
        run_op(4'b1110, -64'sd5, 64'd0);
        run_op(4'b1111, -64'sd5, 64'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 64'd1 << (16 << $urandom_range(0, 2)) >> 1;
            3:       return 64'($urandom_range(0, 7));
            4:       return -64'($urandom_range(1, 9));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            run_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  s;
        logic [63:0] a, b;
        out_ready = 1'b1;
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            s = 4'($urandom_range(0, 9));
            if (s > 4'd7) s = s + 4'd2;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            alusel = s; op_a = a; op_b = b; in_valid = 1'b1;
            #1;
            checks++;
            if (rdy !== 3'b111) begin
                errors++;
                $display("FAIL b2b_ready i=%0d: in_ready=%b required 111", i, rdy);
            end
            step();
            $display("b2b i=%0d sel=%h r16=%h r32=%h r64=%h", i, s, r16, r32, r64);
            checks++;
            if (ov !== 3'b111) begin
                errors++;
                $display("FAIL b2b_valid i=%0d: out_valid=%b required 111", i, ov);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (res_of(k) !== model(width_of(k), s, a, b)) begin
                    errors++;
                    $display("FAIL b2b_result i=%0d w=%0d: got %h required %h",
                             i, width_of(k), res_of(k), model(width_of(k), s, a, b));
                end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c, d;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c = {$urandom, $urandom}; d = {$urandom, $urandom};
        wait_ready();
        out_ready = 1'b0;
        alusel = 4'b0000; op_a = a; op_b = b; in_valid = 1'b1;
        step();
        alusel = 4'b0100; op_a = c; op_b = d;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ov !== 3'b111 || rdy !== 3'b000) begin
                errors++;
                $display("FAIL stall_flags i=%0d: out_valid=%b in_ready=%b required 111/000", i, ov, rdy);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (res_of(k) !== model(width_of(k), 4'b0000, a, b)) begin
                    errors++;
                    $display("FAIL stall_result i=%0d w=%0d: got %h required %h",
                             i, width_of(k), res_of(k), model(width_of(k), 4'b0000, a, b));
                end
            end
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        $display("release r16=%h r32=%h r64=%h", r16, r32, r64);
        checks++;
        if (ov !== 3'b111) begin
            errors++;
            $display("FAIL release_valid: out_valid=%b required 111", ov);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res_of(k) !== model(width_of(k), 4'b0100, c, d)) begin
                errors++;
                $display("FAIL release_result w=%0d: got %h required %h",
                         width_of(k), res_of(k), model(width_of(k), 4'b0100, c, d));
            end
        end
        step();
    endtask

    task automatic test_flush();
        bit leaked = 0;
        wait_ready();
        alusel = 4'b1100; op_a = {$urandom, $urandom}; op_b = 64'($urandom_range(1, 1000)); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        $display("flush out_valid=%b in_ready=%b", ov, rdy);
        checks++;
        if (ov !== 3'b000 || rdy !== 3'b111) begin
            errors++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b required 000/111", ov, rdy);
        end
        for (int i = 0; i < 70; i++) begin
            if (ov !== 3'b000) leaked = 1;
            step();
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL flush_leak: out_valid seen after flush, required never");
        end
        run_op(4'b1101, 64'd100, 64'd7);
    endtask

    task automatic test_rst_abort();
        bit leaked = 0;
        wait_ready();
        out_ready = 1'b0;
        alusel = 4'b0110; op_a = '1; op_b = 64'h5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (ov !== 3'b111) begin
            errors++;
            $display("FAIL rst_hold_pre: out_valid=%b required 111", ov);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("rst_hold out_valid=%b r16=%h r32=%h r64=%h", ov, r16, r32, r64);
        checks++;
        if (ov !== 3'b000 || r16 !== '0 || r32 !== '0 || r64 !== '0) begin
            errors++;
            $display("FAIL rst_hold: out_valid=%b result=%h/%h/%h required 000 and 0", ov, r16, r32, r64);
        end
        out_ready = 1'b1;
        wait_ready();
        alusel = 4'b1000; op_a = '1; op_b = '1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (ov !== 3'b000) leaked = 1;
            step();
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL rst_busy_leak: out_valid seen after reset, required never");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_rst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width taken from operand2[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  abandon in-flight/held operation.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept request this cycle.
REQ-008 operand1  input  XLEN  first operand.
REQ-009 operand2  input  XLEN  second operand / shift amount.
REQ-010 alusel  input  4  operation select.
REQ-011 out_valid  output  1  result held and valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  XLEN  registered result.

Function
REQ-014 Encodings 0000 ADD, 0001 SLL, 0010 SUB, 0011 SRA, 0100 XOR, 0101 SRL (logical), 0110 OR, 0111 AND (the existing 3-bit ALU set, bit3=0).
REQ-015 Encodings 1000 MUL (low XLEN), 1001 MULHU (high XLEN, unsigned), 1100 DIVU, 1101 REMU, 1110 DIV (signed, truncating), 1111 REM (sign of dividend); 1010/1011 reserved.
REQ-016 Accept occurs when in_valid && in_ready; operands and alusel captured only then.
REQ-017 in_ready = (state != BUSY) && (!out_valid || out_ready) && !flush && !rst.
REQ-018 FSM states IDLE, BUSY, HOLD: IDLE->HOLD on accept of bit3=0 or reserved op; IDLE->BUSY on accept of MUL/MULHU/DIV*/REM*; BUSY->HOLD after XLEN iteration cycles; HOLD->IDLE on out_ready with no accept; HOLD->HOLD or HOLD->BUSY on out_ready with simultaneous accept.
REQ-019 out_valid = (state == HOLD); result stable while out_valid && !out_ready.
REQ-020 Latency: single-cycle ops out_valid on cycle after accept; iterative ops out_valid exactly XLEN+1 cycles after accept.
REQ-021 Back-to-back single-cycle ops sustain one result per cycle when out_ready held high.
REQ-022 Shifts use operand2[SHW-1:0] only; ADD/SUB/MUL wrap modulo 2^XLEN.
REQ-023 Reserved encodings produce result 0 with single-cycle latency (never X/Z).
REQ-024 Divide by zero: DIVU/DIV result all-ones, REMU/REM result = operand1; completes in normal XLEN+1 latency.
REQ-025 Signed overflow (DIV of -2^(XLEN-1) by -1): DIV result -2^(XLEN-1), REM result 0.
REQ-026 flush: next state IDLE, out_valid 0 next cycle, iteration discarded; flush has priority over accept and completion in same cycle.
REQ-027 result register retains last value when not updated; only out_valid qualifies it.

Reset
REQ-028 rst high at clock edge: state IDLE, out_valid 0, result 0, iteration counter 0, internal operand registers 0.
REQ-029 rst asserted mid-BUSY or in HOLD aborts without producing a result; rst has priority over flush and accept.
REQ-030 in_ready is 0 during any cycle rst is high; first accept possible on cycle after rst deasserts.

Structure
REQ-031 Shared package alu_pkg holds alusel encoding localparams, FSM state enum, and an is_iterative(alusel) function.
REQ-032 Iterative engine is sub-module muldiv_iter (shift-add multiplier / restoring divider, start/done pulses, XLEN-cycle, one quotient/product bit per cycle); single-cycle ops and FSM remain in alu_seq.
REQ-033 Sign fix-up for DIV/REM (abs before, negate after) lives in muldiv_iter; no combinational path from in_* to out_* or result.

Verification
REQ-034 XLEN=32: ADD 0x7FFFFFFF+1 accepted cycle N -> out_valid at N+1, result 0x80000000; SRA 0x80000000 by 0x24 -> 0xF8000000 (shift 4).
REQ-035 MUL 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000001 at accept+33; MULHU same operands -> 0xFFFFFFFE; in_ready 0 throughout BUSY.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7; DIV -7/2 -> -3, REM -> -1.
REQ-037 Backpressure: out_ready low 5 cycles in HOLD -> result/out_valid unchanged, in_ready 0; out_ready high with in_valid same cycle -> next result next cycle, no bubble.
REQ-038 flush at BUSY cycle 10 of DIVU -> out_valid never asserts for it, in_ready 1 next cycle; rst in HOLD -> out_valid 0 and result 0 next cycle.
REQ-039 Re-run REQ-034/035 at XLEN=16 and 64: MUL latency XLEN+1, reserved alusel 1010 -> result 0 one cycle after accept.
